// File: rtl/cpu_instr_loader.sv
// cpu_instr_loader: CPU-written 64-bit instruction memory streamed to the compute engine on START.
// Defining INSTR_LOADER_LEN_REG_EN enables the LEN register at 0x1FE (instruction count limit).
module cpu_instr_loader #(
    parameter int         INSTR_NUM_BIT = 8,
    parameter logic [7:0] END_OPCODE    = 8'hFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     CPU_instruction_valid,
    input  logic [INSTR_NUM_BIT:0]   CPU_instruction_addr,
    input  logic [31:0]              CPU_instruction_data,
    output logic                     CPU_instruction_irq,
    output logic                     instr_out_valid,
    input  logic                     instr_out_ready,
    output logic [63:0]              instr_out_data,
    output logic [INSTR_NUM_BIT-1:0] instr_out_pc,
    input  logic                     engine_done
);
    localparam int                       DEPTH     = 1 << INSTR_NUM_BIT;
    localparam logic [INSTR_NUM_BIT-1:0] RSVD_SLOT = {INSTR_NUM_BIT{1'b1}};
    localparam logic [INSTR_NUM_BIT-1:0] LAST_SLOT = {{(INSTR_NUM_BIT-1){1'b1}}, 1'b0};
    localparam logic [INSTR_NUM_BIT-1:0] PC_ONE    = {{(INSTR_NUM_BIT-1){1'b0}}, 1'b1};
    localparam logic [INSTR_NUM_BIT-1:0] PC_ZERO   = {INSTR_NUM_BIT{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DISPATCH  = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_FINISH    = 2'd3
    } state_t;

    logic [31:0] mem_lo [DEPTH];
    logic [31:0] mem_hi [DEPTH];
    logic [31:0] rd_lo_q;
    logic [31:0] rd_hi_q;

    state_t                   state_q, state_d;
    logic                     irq_q, irq_d;
    logic                     out_valid_q, out_valid_d;
    logic [63:0]              out_data_q, out_data_d;
    logic [INSTR_NUM_BIT-1:0] out_pc_q, out_pc_d;
    logic                     pf_valid_q, pf_valid_d;
    logic [INSTR_NUM_BIT-1:0] pf_pc_q, pf_pc_d;
    logic [INSTR_NUM_BIT-1:0] fetch_pc_q, fetch_pc_d;
    logic                     fetch_done_q, fetch_done_d;
`ifdef INSTR_LOADER_LEN_REG_EN
    logic [INSTR_NUM_BIT-1:0] len_q, len_d;
    logic [INSTR_NUM_BIT-1:0] hs_cnt_q, hs_cnt_d;
`endif

    logic [INSTR_NUM_BIT-1:0] wr_slot_s;
    logic wr_hi_s, wr_acc_s, rsvd_slot_s, ctrl_wr_s, len_wr_s, mem_we_s, start_s, irq_set_s;
    logic out_free_s, pf_end_s, out_load_s, pf_free_s, rd_en_s, hs_s, last_hs_s, len_stop_s, disp_end_s;

    assign wr_slot_s   = CPU_instruction_addr[INSTR_NUM_BIT:1];
    assign wr_hi_s     = CPU_instruction_addr[0];
    assign wr_acc_s    = CPU_instruction_valid && (state_q == S_IDLE);
    assign rsvd_slot_s = (wr_slot_s == RSVD_SLOT);
    assign ctrl_wr_s   = wr_acc_s && rsvd_slot_s && wr_hi_s;
    assign len_wr_s    = wr_acc_s && rsvd_slot_s && !wr_hi_s;
    assign mem_we_s    = wr_acc_s && !rsvd_slot_s;
    assign start_s     = ctrl_wr_s && CPU_instruction_data[0];

    // Prefetch stage holds the memory read; an END word there is consumed silently
    assign out_free_s = !out_valid_q || instr_out_ready;
    assign pf_end_s   = pf_valid_q && (rd_hi_q[31:24] == END_OPCODE);
    assign out_load_s = (state_q == S_DISPATCH) && pf_valid_q && !pf_end_s && out_free_s;
    assign pf_free_s  = !pf_valid_q || out_load_s;
    assign rd_en_s    = (state_q == S_DISPATCH) && !fetch_done_q && pf_free_s;
    assign hs_s       = out_valid_q && instr_out_ready;
    assign last_hs_s  = hs_s && (out_pc_q == LAST_SLOT);

`ifdef INSTR_LOADER_LEN_REG_EN
    assign irq_set_s  = wr_acc_s;
    assign len_stop_s = hs_s && ((hs_cnt_q + PC_ONE) == len_q);
`else
    assign irq_set_s  = mem_we_s || ctrl_wr_s;
    assign len_stop_s = 1'b0;
`endif
    assign disp_end_s = last_hs_s || (pf_end_s && out_free_s) || len_stop_s;

    // Instruction memory banks with registered read port (no reset on storage)
    always_ff @(posedge clk) begin
        if (mem_we_s && !wr_hi_s) begin
            mem_lo[wr_slot_s] <= CPU_instruction_data;
        end
        if (mem_we_s && wr_hi_s) begin
            mem_hi[wr_slot_s] <= CPU_instruction_data;
        end
        if (rd_en_s) begin
            rd_lo_q <= mem_lo[fetch_pc_q];
            rd_hi_q <= mem_hi[fetch_pc_q];
        end
    end

    // Next-state logic for the control FSM and the two-stage dispatch pipeline
    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_pc_d     = out_pc_q;
        pf_valid_d   = pf_valid_q;
        pf_pc_d      = pf_pc_q;
        fetch_pc_d   = fetch_pc_q;
        fetch_done_d = fetch_done_q;
`ifdef INSTR_LOADER_LEN_REG_EN
        len_d        = len_q;
        hs_cnt_d     = hs_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (irq_set_s) begin
                    irq_d = 1'b1;
                end else begin
                    irq_d = irq_q;
                end
`ifdef INSTR_LOADER_LEN_REG_EN
                if (len_wr_s) begin
                    len_d = CPU_instruction_data[INSTR_NUM_BIT-1:0];
                end else begin
                    len_d = len_q;
                end
`endif
                if (start_s) begin
                    fetch_pc_d   = PC_ZERO;
                    fetch_done_d = 1'b0;
                    pf_valid_d   = 1'b0;
                    out_valid_d  = 1'b0;
`ifdef INSTR_LOADER_LEN_REG_EN
                    hs_cnt_d     = PC_ZERO;
                    state_d      = (len_q == PC_ZERO) ? S_WAIT_DONE : S_DISPATCH;
`else
                    state_d      = S_DISPATCH;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DISPATCH: begin
                if (rd_en_s) begin
                    pf_valid_d = 1'b1;
                    pf_pc_d    = fetch_pc_q;
                    if (fetch_pc_q == LAST_SLOT) begin
                        fetch_done_d = 1'b1;
                    end else begin
                        fetch_pc_d = fetch_pc_q + PC_ONE;
                    end
                end else if (out_load_s) begin
                    pf_valid_d = 1'b0;
                end else begin
                    pf_valid_d = pf_valid_q;
                end
                if (out_load_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {rd_hi_q, rd_lo_q};
                    out_pc_d    = pf_pc_q;
                end else if (hs_s) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
`ifdef INSTR_LOADER_LEN_REG_EN
                if (hs_s) begin
                    hs_cnt_d = hs_cnt_q + PC_ONE;
                end else begin
                    hs_cnt_d = hs_cnt_q;
                end
`endif
                if (disp_end_s) begin
                    state_d     = S_WAIT_DONE;
                    out_valid_d = 1'b0;
                    pf_valid_d  = 1'b0;
                end else begin
                    state_d = S_DISPATCH;
                end
            end
            S_WAIT_DONE: begin
                out_valid_d = 1'b0;
                pf_valid_d  = 1'b0;
                if (engine_done) begin
                    state_d = S_FINISH;
                    irq_d   = 1'b0;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                pf_valid_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            irq_q        <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= 64'h0;
            out_pc_q     <= PC_ZERO;
            pf_valid_q   <= 1'b0;
            pf_pc_q      <= PC_ZERO;
            fetch_pc_q   <= PC_ZERO;
            fetch_done_q <= 1'b0;
`ifdef INSTR_LOADER_LEN_REG_EN
            len_q        <= PC_ZERO;
            hs_cnt_q     <= PC_ZERO;
`endif
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_pc_q     <= out_pc_d;
            pf_valid_q   <= pf_valid_d;
            pf_pc_q      <= pf_pc_d;
            fetch_pc_q   <= fetch_pc_d;
            fetch_done_q <= fetch_done_d;
`ifdef INSTR_LOADER_LEN_REG_EN
            len_q        <= len_d;
            hs_cnt_q     <= hs_cnt_d;
`endif
        end
    end

    assign CPU_instruction_irq = irq_q;
    assign instr_out_valid     = out_valid_q;
    assign instr_out_data      = out_data_q;
    assign instr_out_pc        = out_pc_q;

endmodule

// File: tb/tb_cpu_instr_loader.sv
// Directed bench for cpu_instr_loader: per-edge vector table plus hand-written reset and LEN sequences.
module tb_cpu_instr_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_valid;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_data;
    logic        irq;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_pc;
    logic        done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        ready;
        logic        wr_en;
        logic [8:0]  wr_addr;
        logic [31:0] wr_data;
        logic        done;
        logic        exp_valid;
        logic [7:0]  exp_pc;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    always #5 clk = ~clk;

    cpu_instr_loader dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .CPU_instruction_valid (cpu_valid),
        .CPU_instruction_addr  (cpu_addr),
        .CPU_instruction_data  (cpu_data),
        .CPU_instruction_irq   (irq),
        .instr_out_valid       (out_valid),
        .instr_out_ready       (out_ready),
        .instr_out_data        (out_data),
        .instr_out_pc          (out_pc),
        .engine_done           (done)
    );

    function automatic logic [63:0] prog(input logic [7:0] n);
        return 64'h0000_0001_0000_00A0 + {56'h0, n};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic we, input logic [8:0] a, input logic [31:0] d,
                       input logic dn, input logic ev, input logic [7:0] pc, input logic eirq);
        vecs[nvec].ready     = rdy;
        vecs[nvec].wr_en     = we;
        vecs[nvec].wr_addr   = a;
        vecs[nvec].wr_data   = d;
        vecs[nvec].done      = dn;
        vecs[nvec].exp_valid = ev;
        vecs[nvec].exp_pc    = pc;
        vecs[nvec].exp_irq   = eirq;
        nvec++;
    endtask

    // Called at a negedge; the write lands on the following posedge
    task automatic cpu_wr(input logic [8:0] a, input logic [31:0] d);
        cpu_valid = 1'b1;
        cpu_addr  = a;
        cpu_data  = d;
        @(negedge clk);
        cpu_valid = 1'b0;
    endtask

    task automatic write_slot(input logic [7:0] slot, input logic [63:0] w);
        cpu_wr({slot, 1'b0}, w[31:0]);
        cpu_wr({slot, 1'b1}, w[63:32]);
    endtask

    task automatic step_chk(input string name, input logic ev, input logic [7:0] pc);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, {63'h0, out_valid}, {63'h0, ev});
        if (ev) begin
            chk({name, "_pc"}, {56'h0, out_pc}, {56'h0, pc});
            chk({name, "_data"}, out_data, prog(pc));
        end
    endtask

    task automatic done_pulse(input string name);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk(name, {63'h0, irq}, 64'h0);
    endtask

    initial begin
        rst_n = 1'b0; cpu_valid = 1'b0; cpu_addr = 9'h0; cpu_data = 32'h0;
        out_ready = 1'b1; done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_data", out_data, 64'h0);
        chk("rst_pc", {56'h0, out_pc}, 64'h0);
        chk("rst_irq", {63'h0, irq}, 64'h1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int s = 0; s < 3; s++) write_slot(8'(s), prog(8'(s)));
        write_slot(8'd3, 64'hFF00_0000_0000_0000);
`ifdef INSTR_LOADER_LEN_REG_EN
        cpu_wr(9'h1FE, 32'd200);
`endif

        // run 1: continuous ready, END at slot 3
        add(1'b1, 1'b1, 9'h1FF, 32'h1, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b1, 8'd0, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b1, 8'd1, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b1, 8'd2, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 8'd0, 1'b0);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 8'd0, 1'b0);
        add(1'b1, 1'b1, 9'h008, 32'h11, 1'b0, 1'b0, 8'd0, 1'b1);
        // CTRL write without START bit
        add(1'b1, 1'b1, 9'h1FF, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        // run 2: ready 1,0,0,1 pattern with writes that must be dropped
        add(1'b1, 1'b1, 9'h1FF, 32'h1, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b1, 9'h000, 32'hDEADBEEF, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b1, 9'h1FF, 32'h1, 1'b0, 1'b1, 8'd0, 1'b1);
        add(1'b1, 1'b1, 9'h007, 32'h0, 1'b0, 1'b1, 8'd1, 1'b1);
        add(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b1, 8'd1, 1'b1);
        add(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b1, 8'd1, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b1, 8'd2, 1'b1);
        add(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b1, 8'd2, 1'b1);
        add(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b1, 8'd2, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b1, 9'h007, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 8'd0, 1'b0);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        add(1'b1, 1'b1, 9'h008, 32'h22, 1'b0, 1'b0, 8'd0, 1'b1);
        // run 3: memory must still hold the original program
        add(1'b1, 1'b1, 9'h1FF, 32'h1, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b1, 8'd0, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b1, 8'd1, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b1, 8'd2, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 8'd0, 1'b0);
        add(1'b1, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 8'd0, 1'b0);

        for (int i = 0; i < nvec; i++) begin
            out_ready = vecs[i].ready;
            cpu_valid = vecs[i].wr_en;
            cpu_addr  = vecs[i].wr_addr;
            cpu_data  = vecs[i].wr_data;
            done      = vecs[i].done;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), {63'h0, out_valid}, {63'h0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_irq", i), {63'h0, irq}, {63'h0, vecs[i].exp_irq});
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_pc", i), {56'h0, out_pc}, {56'h0, vecs[i].exp_pc});
                chk($sformatf("vec%0d_data", i), out_data, prog(vecs[i].exp_pc));
            end
            @(negedge clk);
        end
        cpu_valid = 1'b0;
        done      = 1'b0;
        out_ready = 1'b1;

        // asynchronous reset after two handshakes
        cpu_wr(9'h1FF, 32'h1);
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_pc", {56'h0, out_pc}, 64'd2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'h0, out_valid}, 64'h0);
        chk("async_rst_data", out_data, 64'h0);
        chk("async_rst_pc", {56'h0, out_pc}, 64'h0);
        chk("async_rst_irq", {63'h0, irq}, 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef INSTR_LOADER_LEN_REG_EN
        cpu_wr(9'h1FE, 32'd200);
`endif
        cpu_wr(9'h1FF, 32'h1);
        step_chk("post_rst_e1", 1'b0, 8'd0);
        step_chk("post_rst_e2", 1'b1, 8'd0);
        step_chk("post_rst_e3", 1'b1, 8'd1);
        step_chk("post_rst_e4", 1'b1, 8'd2);
        step_chk("post_rst_e5", 1'b0, 8'd0);
        done_pulse("post_rst_irq");

`ifdef INSTR_LOADER_LEN_REG_EN
        write_slot(8'd3, prog(8'd3));
        write_slot(8'd4, prog(8'd4));
        write_slot(8'd5, 64'hFF00_0000_0000_0000);
        cpu_wr(9'h1FE, 32'd2);
        cpu_wr(9'h1FF, 32'h1);
        step_chk("len2_e1", 1'b0, 8'd0);
        step_chk("len2_e2", 1'b1, 8'd0);
        step_chk("len2_e3", 1'b1, 8'd1);
        step_chk("len2_e4", 1'b0, 8'd0);
        step_chk("len2_e5", 1'b0, 8'd0);
        done_pulse("len2_irq");
        @(negedge clk);
        cpu_wr(9'h1FE, 32'd0);
        chk("len0_wr_irq", {63'h0, irq}, 64'h1);
        cpu_wr(9'h1FF, 32'h1);
        step_chk("len0_e1", 1'b0, 8'd0);
        step_chk("len0_e2", 1'b0, 8'd0);
        step_chk("len0_e3", 1'b0, 8'd0);
        done_pulse("len0_irq");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
